// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse receive path.
//   - rx_state_t : decoder state encoding (IDLE / MARK / GAP / DISCARD)
//   - timing thresholds, counted in Morse units
//   - ASCII_SPACE: character emitted for a word gap
//   - sat_inc3   : 3-bit increment that sticks at 7
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no partial character held
    MARK    = 2'd1,  // line is keyed, measuring the mark length
    GAP     = 2'd2,  // partial character held, measuring the space
    DISCARD = 2'd3   // malformed character, waiting for a letter gap
  } rx_state_t;

  localparam logic [2:0] DASH_MIN   = 3'd2;  // marks of 2 or more units are dashes
  localparam logic [2:0] MARK_MAX   = 3'd4;  // longer marks are malformed
  localparam logic [2:0] LETTER_GAP = 3'd3;  // space that closes a character
  localparam logic [2:0] WORD_GAP   = 3'd7;  // space that produces a word break
  localparam logic [2:0] MAX_ELEMS  = 3'd6;  // pattern register capacity

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/morse2ascii.sv
// morse2ascii: combinational Morse pattern to ASCII lookup.
//   len   [2:0] number of valid elements (1..6)
//   bits  [5:0] elements, newest at bit0, 1 = dash, 0 = dot
//   ascii [7:0] uppercase A-Z or 0-9 when hit, else 0
//   hit         pattern is a known character
// The first element sent sits at bit[len-1], so patterns read left to right
// in the usual dot/dash notation.
module morse2ascii
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [5:0] bits,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = 8'h00;
    case (len)
      3'd1: ascii = bits[0] ? "T" : "E";
      3'd2: begin
        case (bits[1:0])
          2'b00:   ascii = "I";
          2'b01:   ascii = "A";
          2'b10:   ascii = "N";
          default: ascii = "M";
        endcase
      end
      3'd3: begin
        case (bits[2:0])
          3'b000:  ascii = "S";
          3'b001:  ascii = "U";
          3'b010:  ascii = "R";
          3'b011:  ascii = "W";
          3'b100:  ascii = "D";
          3'b101:  ascii = "K";
          3'b110:  ascii = "G";
          default: ascii = "O";
        endcase
      end
      3'd4: begin
        case (bits[3:0])
          4'b0000: ascii = "H";
          4'b0001: ascii = "V";
          4'b0010: ascii = "F";
          4'b0100: ascii = "L";
          4'b0110: ascii = "P";
          4'b0111: ascii = "J";
          4'b1000: ascii = "B";
          4'b1001: ascii = "X";
          4'b1010: ascii = "C";
          4'b1011: ascii = "Y";
          4'b1100: ascii = "Z";
          4'b1101: ascii = "Q";
          default: ascii = 8'h00;
        endcase
      end
      3'd5: begin
        case (bits[4:0])
          5'b11111: ascii = "0";
          5'b01111: ascii = "1";
          5'b00111: ascii = "2";
          5'b00011: ascii = "3";
          5'b00001: ascii = "4";
          5'b00000: ascii = "5";
          5'b10000: ascii = "6";
          5'b11000: ascii = "7";
          5'b11100: ascii = "8";
          5'b11110: ascii = "9";
          default:  ascii = 8'h00;
        endcase
      end
      default: ascii = 8'h00;
    endcase
    // Every table entry is a printable character, so non-zero means found.
    hit = (ascii != 8'h00);
  end

endmodule

// File: rtl/morse_rx.sv
// morse_rx: Morse line receiver and decoder.
//   clk          system clock
//   arst         synchronous active-high reset
//   morse_in     keyed line (1 = mark), may be asynchronous to clk
//   ascii_out    decoded character, held stable while ascii_valid=1
//   ascii_valid  character available
//   ascii_ready  consumer accepts
//   decode_err   one-cycle pulse: malformed or unknown character dropped
//   overrun      one-cycle pulse: character dropped, output still occupied
//   dbg_state    current decoder state (rx_state_t encoding)
//
// Output handshake: a character transfers on every clk edge where
// ascii_valid && ascii_ready. ascii_valid never drops and ascii_out never
// changes until that transfer happens. A new character arriving in the same
// cycle as a transfer replaces the consumed one without loss.
//
// The line is sampled once per Morse unit (the tick); all decoding advances
// only on tick cycles.
module morse_rx
  import morse_pkg::*;
#(
  parameter int PRESCALER = 100000
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       morse_in,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       decode_err,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam int CW = (PRESCALER > 2) ? $clog2(PRESCALER) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(PRESCALER - 1);

  // Line synchronizer and unit tick
  logic          sync_a;
  logic          s;
  logic [CW-1:0] tick_cnt;
  logic          tick;

  always_ff @(posedge clk) begin
    if (arst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= morse_in;
      s      <= sync_a;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (arst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  // Decoder state
  rx_state_t  state, state_n;
  logic [2:0] mark_cnt, mark_cnt_n;
  logic [2:0] gap_cnt, gap_cnt_n;
  logic [2:0] len, len_n;
  logic [5:0] bits, bits_n;
  logic       space_armed, space_armed_n;
  logic       emit;
  logic [7:0] emit_char;
  logic       err;
  logic [7:0] lut_ascii;
  logic       lut_hit;

  morse2ascii u_lut (
    .len   (len),
    .bits  (bits),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  always_ff @(posedge clk) begin
    if (arst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    mark_cnt_n    = mark_cnt;
    gap_cnt_n     = gap_cnt;
    len_n         = len;
    bits_n        = bits;
    space_armed_n = space_armed;
    emit          = 1'b0;
    emit_char     = 8'h00;
    err           = 1'b0;

    if (tick) begin
      case (state)
        IDLE: begin
          if (s) begin
            state_n    = MARK;
            mark_cnt_n = 3'd1;
          end else begin
            gap_cnt_n = sat_inc3(gap_cnt);
            // Fires only on the tick the count reaches the word gap, and
            // disarms itself, so one idle period yields at most one space.
            if (gap_cnt != WORD_GAP && gap_cnt_n == WORD_GAP && space_armed) begin
              emit          = 1'b1;
              emit_char     = ASCII_SPACE;
              space_armed_n = 1'b0;
            end
          end
        end

        MARK: begin
          if (s) begin
            mark_cnt_n = sat_inc3(mark_cnt);
          end else begin
            // Gap counting starts from the end of the mark in every case.
            gap_cnt_n = 3'd1;
            if (mark_cnt > MARK_MAX || len == MAX_ELEMS) begin
              state_n = DISCARD;
              err     = 1'b1;
            end else begin
              bits_n  = {bits[4:0], (mark_cnt >= DASH_MIN)};
              len_n   = len + 3'd1;
              state_n = GAP;
            end
          end
        end

        GAP: begin
          if (s) begin
            state_n    = MARK;
            mark_cnt_n = 3'd1;
          end else begin
            gap_cnt_n = gap_cnt + 3'd1;
            if (gap_cnt_n == LETTER_GAP) begin
              if (lut_hit) begin
                emit          = 1'b1;
                emit_char     = lut_ascii;
                space_armed_n = 1'b1;
              end else begin
                err = 1'b1;
              end
              len_n   = 3'd0;
              bits_n  = 6'd0;
              state_n = IDLE;
            end
          end
        end

        DISCARD: begin
          if (s) begin
            gap_cnt_n = 3'd0;
          end else begin
            gap_cnt_n = sat_inc3(gap_cnt);
            if (gap_cnt_n == LETTER_GAP) begin
              len_n   = 3'd0;
              bits_n  = 6'd0;
              state_n = IDLE;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      mark_cnt    <= 3'd0;
      gap_cnt     <= 3'd0;
      len         <= 3'd0;
      bits        <= 6'd0;
      space_armed <= 1'b0;
    end else begin
      mark_cnt    <= mark_cnt_n;
      gap_cnt     <= gap_cnt_n;
      len         <= len_n;
      bits        <= bits_n;
      space_armed <= space_armed_n;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (arst) begin
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      decode_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      decode_err <= err;
      overrun    <= 1'b0;
      if (emit) begin
        if (!ascii_valid || ascii_ready) begin
          ascii_out   <= emit_char;
          ascii_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ascii_valid && ascii_ready) begin
        ascii_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_morse_rx.sv
// tb_morse_rx: self-checking bench for morse_rx with PRESCALER=4.
// Line levels are driven in whole Morse units. A run-level reference model
// turns each driven run into expected characters, error counts and overrun
// counts; a monitor checks every accepted character against the queue.
module tb_morse_rx;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic       morse_in;
  logic       ascii_ready;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       decode_err;
  logic       overrun;
  logic [1:0] dbg_state;

  morse_rx #(.PRESCALER(P)) dut (
    .clk         (clk),
    .arst        (arst),
    .morse_in    (morse_in),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .decode_err  (decode_err),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         obs_err = 0;
  int         exp_ovr = 0;
  int         obs_ovr = 0;

  // Reference model state
  string      codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                            "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                            "-.--", "--..", "-----", ".----", "..---", "...--",
                            "....-", ".....", "-....", "--...", "---..", "----."};
  string      alnum = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string      m_pat = "";
  bit         m_discard = 1'b0;
  bit         m_armed = 1'b0;
  int         m_low = 0;
  bit         m_capture = 1'b0;
  logic [7:0] m_out[$];

  bit         rand_rdy = 1'b0;
  int         stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lookup(input string p);
    for (int i = 0; i < 36; i++) if (codes[i] == p) return i;
    return -1;
  endfunction

  function automatic void m_emit(input logic [7:0] c);
    if (m_capture) m_out.push_back(c);
    else           exp_q.push_back(c);
  endfunction

  function automatic void m_reset();
    m_pat     = "";
    m_discard = 1'b0;
    m_armed   = 1'b0;
    m_low     = 0;
  endfunction

  // A mark run: 1 unit is a dot, 2..4 a dash, 5+ malformed; a seventh
  // element is malformed. Inside a discarded character marks are ignored.
  function automatic void m_high_run(input int n);
    if (!m_discard) begin
      if (n >= 5 || m_pat.len() == 6) begin
        exp_err++;
        m_discard = 1'b1;
        m_pat     = "";
      end else if (n == 1) begin
        m_pat = {m_pat, "."};
      end else begin
        m_pat = {m_pat, "-"};
      end
    end
    m_low = 0;
  endfunction

  // A space run, continuing any space already in progress. Crossing 3 units
  // closes the character; crossing 7 units gives a space if a letter since
  // the last space armed it.
  function automatic void m_low_run(input int n);
    int total;
    int idx;
    total = m_low + n;
    if (m_low < 3 && total >= 3) begin
      if (m_discard) begin
        m_discard = 1'b0;
        m_pat     = "";
      end else if (m_pat.len() > 0) begin
        idx = lookup(m_pat);
        if (idx >= 0) begin
          m_emit(alnum[idx]);
          m_armed = 1'b1;
        end else begin
          exp_err++;
        end
        m_pat = "";
      end
    end
    if (m_low < 7 && total >= 7 && m_armed) begin
      m_emit(8'h20);
      m_armed = 1'b0;
    end
    m_low = (total > 1000) ? 1000 : total;
  endfunction

  // Driver tasks: always entered and left at posedge + #1
  task automatic seg(input logic lvl, input int units);
    if (lvl) m_high_run(units);
    else     m_low_run(units);
    morse_in = lvl;
    repeat (units * P) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pat(input string pat, input int dash_u, input int gap_u);
    for (int i = 0; i < pat.len(); i++) begin
      seg(1'b1, (pat[i] == "-") ? dash_u : 1);
      seg(1'b0, (i == pat.len() - 1) ? gap_u : 1);
    end
  endtask

  task automatic end_scenario(input string name);
    seg(1'b0, 10);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    chk({name, "_decode_err_count"}, obs_err, exp_err);
    chk({name, "_overrun_count"}, obs_ovr, exp_ovr);
  endtask

  // Monitor: pulses counted once per high cycle, characters popped on transfer
  always @(negedge clk) begin
    if (!arst) begin
      if (decode_err) obs_err++;
      if (overrun) obs_ovr++;
      if (ascii_valid && ascii_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_char: got %0h expected none", ascii_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (ascii_out !== e) begin
            failures++;
            $display("FAIL char: got %0h expected %0h", ascii_out, e);
          end
        end
      end
    end
  end

  // Randomized consumer: stalls at most a few cycles
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      if (ascii_valid && stall >= 2) ascii_ready = 1'b1;
      else                           ascii_ready = ($urandom_range(0, 2) != 0);
      stall = (ascii_valid && !ascii_ready) ? stall + 1 : 0;
    end
  end

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ascii_out"}, ascii_out, 8'h00);
    chk({name, "_ascii_valid"}, ascii_valid, 1'b0);
    chk({name, "_decode_err"}, decode_err, 1'b0);
    chk({name, "_overrun"}, overrun, 1'b0);
    chk({name, "_state"}, dbg_state, 2'd0);
  endtask

  initial begin
    string pat;
    int    idx;
    arst        = 1'b1;
    morse_in    = 1'b0;
    ascii_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    arst = 1'b0;
    m_reset();

    // 1: 'E'
    send_pat(".", 1, 4);
    end_scenario("e");

    // 2: 'T' then 'E' with a word gap
    send_pat("-", 3, 3);
    send_pat(".", 1, 20);
    end_scenario("te_word");

    // 3: 'A' and '5' back to back
    send_pat(".-", 3, 3);
    send_pat(".....", 3, 3);
    end_scenario("a5");

    // 4: seven dots, 6-unit mark, unmapped pattern, then 'E'
    send_pat(".......", 3, 3);
    seg(1'b1, 6);
    seg(1'b0, 3);
    send_pat("..--", 3, 3);
    send_pat(".", 1, 3);
    end_scenario("errors");

    // 5: overrun while the consumer is stalled
    ascii_ready = 1'b0;
    m_capture   = 1'b1;
    send_pat(".", 1, 3);
    seg(1'b1, 3);
    seg(1'b0, 4);
    m_capture = 1'b0;
    if (m_out.size() > 0) exp_q.push_back(m_out[0]);
    exp_ovr += m_out.size() - 1;
    m_out.delete();
    chk("overrun_held_char", ascii_out, 8'h45);
    chk("overrun_held_valid", ascii_valid, 1'b1);
    chk("overrun_pulses", obs_ovr, exp_ovr);
    ascii_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("overrun_consumed_valid", ascii_valid, 1'b0);
    end_scenario("overrun");

    // 6: reset during the second element of 'A', then 'N'
    seg(1'b1, 1);
    seg(1'b0, 1);
    morse_in = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    arst     = 1'b1;
    morse_in = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset");
    arst = 1'b0;
    m_reset();
    seg(1'b0, 4);
    send_pat("-.", 3, 3);
    end_scenario("after_reset");

    // Randomized traffic with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          seg(1'b1, $urandom_range(5, 7));
          seg(1'b0, $urandom_range(3, 5));
        end else begin
          send_pat(".......", 2, $urandom_range(3, 8));
        end
      end else begin
        idx = $urandom_range(0, 35);
        pat = codes[idx];
        for (int i = 0; i < pat.len(); i++) begin
          seg(1'b1, (pat[i] == "-") ? $urandom_range(2, 4) : 1);
          if (i == pat.len() - 1)
            seg(1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(7, 10) : $urandom_range(3, 6));
          else
            seg(1'b0, $urandom_range(1, 2));
        end
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ascii_ready = 1'b1;
    end_scenario("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_rx.md
Name: morse_rx

Overview:
- Receive end of the Morse link: samples a single-bit on/off keyed line at the Morse unit rate and recovers dots, dashes, letter gaps and word gaps.
- Emits the decoded ASCII characters (A–Z, 0–9, space) through a valid/ready output port.
- Sits between the line (loopback from morse_tx, or external) and the consuming logic, such as a FIFO or UART bridge.

Parameters:
- PRESCALER, 100000, clk cycles per Morse time unit; must match the transmitter unit length, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arst  input  1  reset, synchronous, active-high.
- morse_in  input  1  keyed line, 1 = mark; may be asynchronous to clk.
- ascii_out  output  8  decoded character; stable while ascii_valid=1.
- ascii_valid  output  1  character available.
- ascii_ready  input  1  consumer accepts when ascii_valid && ascii_ready.
- decode_err  output  1  one-cycle pulse: malformed or unknown symbol dropped.
- overrun  output  1  one-cycle pulse: new character dropped because output still occupied.

Behaviour:
- Reset (arst=1 at a clk edge) clears everything:
  - ascii_out=0, ascii_valid=0, decode_err=0, overrun=0.
  - Synchronizer flops=0, tick counter=0, state=IDLE, pattern/len/gap_cnt/mark_cnt=0, space_armed=0.
  - Reset mid-character discards the partial character; no output is produced for it.
- Synchronizer: two flops on morse_in; s = second-flop value.
- Tick: a counter runs 0..PRESCALER-1 and wraps. tick=1 when count==PRESCALER-1. All decode logic advances only on tick cycles, sampling s.
- Pattern register: len[2:0] (0..6) and bits[5:0], shifted left with the newest element at bit0; 1 = dash, 0 = dot.
- State machine, evaluated on tick:
  - IDLE (no partial char):
    - s=1 → MARK, mark_cnt=1.
    - s=0 → gap_cnt++ (saturates at 7). On the tick gap_cnt becomes 7 with space_armed=1: emit 0x20 and clear space_armed.
  - MARK:
    - s=1 → mark_cnt++ (saturates at 7).
    - s=0 → classify mark_cnt: 1 = dot; 2..4 = dash; ≥5 = error → DISCARD.
    - If len==6 before the append → error → DISCARD.
    - Otherwise append the element and go to GAP with gap_cnt=1.
  - GAP (partial char held):
    - s=1 → MARK, mark_cnt=1 (intra-character gap).
    - s=0 → gap_cnt++. On the tick gap_cnt reaches 3: look up the pattern.
      - Hit: emit the character and set space_armed.
      - Miss: pulse decode_err.
      - Either way clear the pattern and go to IDLE, keeping gap_cnt=3 so a word gap is counted from the end of the mark.
  - DISCARD:
    - decode_err pulses on entry.
    - s=1 → gap_cnt=0.
    - s=0 → gap_cnt++; at 3, clear the pattern and go to IDLE. space_armed is unchanged.
- Space rule: at most one 0x20 per idle period. No space after reset or after a previous space.
- Emit: the character is registered into ascii_out, and ascii_valid is set on the clk edge ending the tick cycle.
  - ascii_valid && ascii_ready in the same cycle as an emit: the old character is consumed and the new one loaded; no overrun.
  - ascii_valid && !ascii_ready at an emit: keep the old character, drop the new one, pulse overrun.
- Element-to-output latency: 2 clk (synchronizer) + up to PRESCALER clk (tick phase) + 1 clk.
- decode_err and overrun are registered and last exactly one clk.

Decomposition:
- morse_pkg holds:
  - state encodings IDLE/MARK/GAP/DISCARD;
  - thresholds DASH_MIN=2, MARK_MAX=4, LETTER_GAP=3, WORD_GAP=7, MAX_ELEMS=6;
  - ASCII_SPACE=8'h20.
- One combinational sub-module, morse2ascii: inputs len[2:0], bits[5:0]; outputs ascii[7:0], hit. Covers A–Z (uppercase) and 0–9. It is the inverse table of ascii2morse.

Test Plan:
All scenarios run with PRESCALER=4; a unit = 4 clk, and line levels are held in whole units.
1. 'E': high 1u, low 4u → single ascii_valid with ascii_out=0x45; no decode_err; no space.
2. 'T' then 'E', word gap: high 3u, low 3u, high 1u, low 20u → 0x54, 0x45, then exactly one 0x20 about 7u after the last mark ends; nothing further.
3. 'A' ".-" and '5' "....." back-to-back with 3u letter gap, ascii_ready=1 → 0x41 then 0x35; decode_err never asserted.
4. Errors:
   - 7 dots → decode_err pulse, no character.
   - Mark of 6u → decode_err.
   - "..--" (unmapped) → decode_err, no output.
   - The following 'E' still decodes as 0x45.
5. Overrun: ascii_ready=0, send 'E' then 'T' → ascii_out stays 0x45, overrun pulses once. Raise ascii_ready → 0x45 consumed, ascii_valid drops.
6. Reset mid-character: arst=1 for one clk during the second element of 'A' → all outputs 0 next cycle; subsequent 'N' "-." → 0x4E, no spurious space or error.
